mem_stage: RTL and testbench
============================

# mem_stage

Memory-access stage of the 5-stage MIPS pipeline: consumes the EX/MEM pipeline fields and issues loads/stores to data memory over a req/ack handshake. It stalls upstream stages while an access is outstanding and resolves branches from the EX/MEM zero flag. It produces the packed 71-bit bus loaded into the MEM/WB register. Sits between the EX/MEM register and the MEM/WB register; the data memory sits behind the dmem_* port.

## Interface
- TIMEOUT, 15: max cycles waiting for dmem_ack before abort (2..255)
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous reset, active-low
- ex_mem_wr_con  in  2  [1]=reg_write, [0]=mem_to_reg
- ex_mem_mem_con  in  3  [2]=branch, [1]=mem_read, [0]=mem_write
- ex_mem_pc_4_off  in  32  branch target (PC+4+offset)
- ex_mem_zero  in  1  ALU zero flag
- ex_mem_alu_res  in  32  ALU result / memory byte address
- ex_mem_data2  in  32  store data
- ex_mem_rd  in  5  destination register
- dmem_req  out  1  access request, held until ack or abort
- dmem_we  out  1  1=write, 0=read; stable while dmem_req
- dmem_addr  out  32  word address, stable while dmem_req
- dmem_wdata  out  32  store data, stable while dmem_req
- dmem_ack  in  1  one-cycle completion strobe
- dmem_rdata  in  32  read data, valid with dmem_ack
- stall  out  1  combinational; freezes PC, IF/ID, ID/EX, EX/MEM
- pc_src  out  1  combinational: branch & zero
- branch_target  out  32  combinational: ex_mem_pc_4_off
- mem_err  out  1  one-cycle pulse on timeout abort
- mem_wb_out  out  71  {wr_con[70:69], read_data[68:37], alu_res[36:5], rd[4:0]}

## Operation
- Access = mem_read | mem_write. mem_read and mem_write both set: treated as read.
- States: IDLE, BUSY, DONE.
- IDLE, no access: at next edge mem_wb_out <= {wr_con, 32'h0, alu_res, rd}; stay IDLE; stall=0.
- IDLE, access: stall=1; at next edge latch addr={alu_res[31:2],2'b00}, wdata=data2, we=mem_write & ~mem_read, wr_con, alu_res, rd; clear counter; mem_wb_out <= 0 (bubble); go BUSY.
- BUSY: dmem_req=1, stall=1, mem_wb_out <= 0 each edge.
  - dmem_ack: capture dmem_rdata (0 for writes), go DONE.
  - no ack, counter == TIMEOUT-1: capture 0, pulse mem_err next cycle, go DONE.
  - otherwise counter++.
- DONE: dmem_req=0, stall=0; at edge mem_wb_out <= {latched wr_con, captured data, latched alu_res, latched rd}; go IDLE. The held EX/MEM instruction advances on the same edge and is not re-issued.
- Timeout abort: write-back still occurs with read_data=0 (mem_err flags it to the hazard/exception logic).
- pc_src/branch_target: pure functions of the current EX/MEM inputs in every state; the EX/MEM contents are frozen during a stall, so they stay stable.
- Address bits [1:0] ignored; no misalignment trap.

## Timing
- Reset (rst_n=0 at edge): state=IDLE, counter=0, dmem_req=0, dmem_we=0, dmem_addr=0, dmem_wdata=0, mem_wb_out=0, mem_err=0. Reset overrides a BUSY access; dmem_req drops at that edge. A late ack after reset is ignored.
- Non-memory op: 1 cycle to mem_wb_out.
- Memory op: stall high from IDLE cycle through the ack cycle. Ack in BUSY cycle k (k=1 is first req cycle) -> DONE at k+1 -> mem_wb_out valid after edge ending DONE. Total stall cycles = k+1.
- Ack in first BUSY cycle permitted (zero-wait memory): stall for 2 cycles.
- dmem_ack outside BUSY ignored.
- Timeout: dmem_req high exactly TIMEOUT cycles; mem_err high the cycle state=DONE.
- Branch plus memory op in the same instruction cannot occur; if it does, pc_src still follows the inputs.

## Test plan
- Reset mid-BUSY: rst_n=0 on the 3rd req cycle -> next cycle dmem_req=0, stall=0, mem_wb_out=0.
- ALU op wr_con=2'b10, alu_res=32'h0000_0042, rd=5'd3 -> next cycle mem_wb_out={2'b10, 32'h0, 32'h42, 5'd3}, stall never high.
- lw alu_res=32'h0000_0103, ack after 3 req cycles with rdata=32'hDEAD_BEEF -> dmem_addr=32'h100; stall high 4 cycles; mem_wb_out={2'b11, 32'hDEADBEEF, 32'h103, rd}.
- sw data2=32'h1234_5678, zero-wait ack -> dmem_we=1, dmem_wdata=32'h12345678; stall for 2 cycles; mem_wb_out wr_con=2'b00.
- lw with no ack, TIMEOUT=15 -> dmem_req high exactly 15 cycles; mem_err pulses once; read_data=0.
- beq mem_con=3'b100, zero=1, pc_4_off=32'h0000_0040 -> same cycle pc_src=1, branch_target=32'h40; zero=0 -> pc_src=0.

Source files
------------

// File: rtl/mem_stage.sv
// MIPS MEM stage: issues data-memory loads/stores over req/ack, stalls the front of the
// pipeline while an access is outstanding, and builds the 71-bit MEM/WB bus.
module mem_stage #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  ex_mem_wr_con,
    input  logic [2:0]  ex_mem_mem_con,
    input  logic [31:0] ex_mem_pc_4_off,
    input  logic        ex_mem_zero,
    input  logic [31:0] ex_mem_alu_res,
    input  logic [31:0] ex_mem_data2,
    input  logic [4:0]  ex_mem_rd,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        stall,
    output logic        pc_src,
    output logic [31:0] branch_target,
    output logic        mem_err,
    output logic [70:0] mem_wb_out,
    output logic [1:0]  dbg_state
);

    // Handshake: dmem_req stays high with we/addr/wdata frozen until a one-cycle dmem_ack
    // (rdata valid alongside it) or until TIMEOUT request cycles elapse; ack outside BUSY is ignored.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [7:0] LP_CNT_LAST = 8'(TIMEOUT - 1);

    state_t      r_state;
    state_t      w_next_state;
    logic        w_access;
    logic        w_is_write;
    logic        w_timeout;
    logic        w_stall;
    logic        w_req;
    logic [7:0]  r_cnt;
    logic        r_we;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [1:0]  r_wr_con;
    logic [31:0] r_alu_res;
    logic [4:0]  r_rd;
    logic [31:0] r_rdata;
    logic        r_mem_err;
    logic [70:0] r_mem_wb;

    assign w_access   = ex_mem_mem_con[1] | ex_mem_mem_con[0];
    // Read wins when both mem_read and mem_write are set.
    assign w_is_write = ex_mem_mem_con[0] & ~ex_mem_mem_con[1];
    assign w_timeout  = (r_cnt == LP_CNT_LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (w_access) w_next_state = S_BUSY;
            S_BUSY:  if (dmem_ack || w_timeout) w_next_state = S_DONE;
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_comb begin
        w_stall = 1'b0;
        w_req   = 1'b0;
        case (r_state)
            S_IDLE: w_stall = w_access;
            S_BUSY: begin
                w_stall = 1'b1;
                w_req   = 1'b1;
            end
            default: begin
                w_stall = 1'b0;
                w_req   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt     <= 8'd0;
            r_we      <= 1'b0;
            r_addr    <= 32'h0;
            r_wdata   <= 32'h0;
            r_wr_con  <= 2'b00;
            r_alu_res <= 32'h0;
            r_rd      <= 5'd0;
            r_rdata   <= 32'h0;
            r_mem_err <= 1'b0;
            r_mem_wb  <= 71'h0;
        end else begin
            r_mem_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_access) begin
                        r_addr    <= {ex_mem_alu_res[31:2], 2'b00};
                        r_wdata   <= ex_mem_data2;
                        r_we      <= w_is_write;
                        r_wr_con  <= ex_mem_wr_con;
                        r_alu_res <= ex_mem_alu_res;
                        r_rd      <= ex_mem_rd;
                        r_cnt     <= 8'd0;
                        r_mem_wb  <= 71'h0;
                    end else begin
                        r_mem_wb <= {ex_mem_wr_con, 32'h0, ex_mem_alu_res, ex_mem_rd};
                    end
                end
                S_BUSY: begin
                    r_mem_wb <= 71'h0;
                    if (dmem_ack) begin
                        r_rdata <= r_we ? 32'h0 : dmem_rdata;
                    end else if (w_timeout) begin
                        r_rdata   <= 32'h0;
                        r_mem_err <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                S_DONE: begin
                    r_mem_wb <= {r_wr_con, r_rdata, r_alu_res, r_rd};
                end
                default: r_mem_wb <= 71'h0;
            endcase
        end
    end

    assign dmem_req      = w_req;
    assign stall         = w_stall;
    assign dmem_we       = r_we;
    assign dmem_addr     = r_addr;
    assign dmem_wdata    = r_wdata;
    assign pc_src        = ex_mem_mem_con[2] & ex_mem_zero;
    assign branch_target = ex_mem_pc_4_off;
    assign mem_err       = r_mem_err;
    assign mem_wb_out    = r_mem_wb;
    assign dbg_state     = r_state;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: ALU pass-through, loads/stores with varied ack latency,
// timeout abort, reset during an access, and branch resolution.
module tb_mem_stage;

    logic        clk;
    logic        rst_n;
    logic [1:0]  ex_mem_wr_con;
    logic [2:0]  ex_mem_mem_con;
    logic [31:0] ex_mem_pc_4_off;
    logic        ex_mem_zero;
    logic [31:0] ex_mem_alu_res;
    logic [31:0] ex_mem_data2;
    logic [4:0]  ex_mem_rd;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    logic        stall;
    logic        pc_src;
    logic [31:0] branch_target;
    logic        mem_err;
    logic [70:0] mem_wb_out;
    logic [1:0]  dbg_state;

    int n_checks = 0;
    int n_fail   = 0;
    logic [70:0] exp_q[$];

    int          stall_n, req_n, err_n;
    logic        we_s;
    logic [31:0] addr_s, wdata_s;
    logic        done_s;

    mem_stage #(.TIMEOUT(15)) dut (
        .clk(clk), .rst_n(rst_n),
        .ex_mem_wr_con(ex_mem_wr_con), .ex_mem_mem_con(ex_mem_mem_con),
        .ex_mem_pc_4_off(ex_mem_pc_4_off), .ex_mem_zero(ex_mem_zero),
        .ex_mem_alu_res(ex_mem_alu_res), .ex_mem_data2(ex_mem_data2), .ex_mem_rd(ex_mem_rd),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .stall(stall), .pc_src(pc_src), .branch_target(branch_target),
        .mem_err(mem_err), .mem_wb_out(mem_wb_out), .dbg_state(dbg_state)
    );

    // Clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [70:0] obs, input logic [70:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] wr, input logic [2:0] mc, input logic [31:0] alu,
                         input logic [31:0] d2, input logic [4:0] rd);
        ex_mem_wr_con  = wr;
        ex_mem_mem_con = mc;
        ex_mem_alu_res = alu;
        ex_mem_data2   = d2;
        ex_mem_rd      = rd;
    endtask

    // Runs one memory op from the IDLE cycle through DONE; ack_at=0 means never ack.
    task automatic mem_op(input int ack_at, input logic [31:0] rdata);
        stall_n = 0; req_n = 0; err_n = 0; done_s = 1'b0;
        for (int cyc = 0; cyc < 40 && !done_s; cyc++) begin
            dmem_ack = 1'b0;
            #1;
            if (stall) stall_n++;
            if (mem_err) err_n++;
            if (dmem_req) begin
                req_n++;
                if (req_n == 1) begin
                    addr_s = dmem_addr; we_s = dmem_we; wdata_s = dmem_wdata;
                end
                if (req_n == ack_at) begin
                    dmem_ack   = 1'b1;
                    dmem_rdata = rdata;
                end
            end
            if (cyc > 0 && !stall) done_s = 1'b1;
            tick();
        end
        dmem_ack = 1'b0;
        check_eq("op_completed", 71'(done_s), 71'd1);
    endtask

    initial begin
        rst_n = 1'b0; dmem_ack = 1'b0; dmem_rdata = 32'h0;
        ex_mem_pc_4_off = 32'h0; ex_mem_zero = 1'b0;
        drive(2'b00, 3'b000, 32'h0, 32'h0, 5'd0);
        tick(); tick();
        check_eq("rst_wb", mem_wb_out, 71'h0);
        check_eq("rst_req", 71'(dmem_req), 71'd0);
        check_eq("rst_stall", 71'(stall), 71'd0);
        check_eq("rst_err", 71'(mem_err), 71'd0);
        check_eq("rst_addr", 71'(dmem_addr), 71'd0);
        check_eq("rst_state", 71'(dbg_state), 71'd0);
        rst_n = 1'b1;

        // ALU op, with a stray ack that must be ignored
        drive(2'b10, 3'b000, 32'h0000_0042, 32'h0, 5'd3);
        dmem_ack = 1'b1; dmem_rdata = 32'hFFFF_FFFF;
        #1;
        check_eq("alu_stall", 71'(stall), 71'd0);
        exp_q.push_back({2'b10, 32'h0, 32'h0000_0042, 5'd3});
        tick();
        dmem_ack = 1'b0;
        check_eq("alu_wb", mem_wb_out, exp_q.pop_front());
        check_eq("alu_req", 71'(dmem_req), 71'd0);

        // lw, ack in 3rd request cycle
        drive(2'b11, 3'b010, 32'h0000_0103, 32'h0, 5'd7);
        exp_q.push_back({2'b11, 32'hDEAD_BEEF, 32'h0000_0103, 5'd7});
        mem_op(3, 32'hDEAD_BEEF);
        drive(2'b00, 3'b000, 32'h0, 32'h0, 5'd0);
        check_eq("lw_wb", mem_wb_out, exp_q.pop_front());
        check_eq("lw_addr", 71'(addr_s), 71'h100);
        check_eq("lw_we", 71'(we_s), 71'd0);
        check_eq("lw_stall_cycles", 71'(stall_n), 71'd4);
        check_eq("lw_req_cycles", 71'(req_n), 71'd3);
        check_eq("lw_err", 71'(err_n), 71'd0);

        // sw, zero-wait ack; memory returns junk that must not be captured
        drive(2'b00, 3'b001, 32'h0000_0200, 32'h1234_5678, 5'd0);
        exp_q.push_back({2'b00, 32'h0, 32'h0000_0200, 5'd0});
        mem_op(1, 32'hAAAA_5555);
        drive(2'b00, 3'b000, 32'h0, 32'h0, 5'd0);
        check_eq("sw_wb", mem_wb_out, exp_q.pop_front());
        check_eq("sw_we", 71'(we_s), 71'd1);
        check_eq("sw_wdata", 71'(wdata_s), 71'h1234_5678);
        check_eq("sw_addr", 71'(addr_s), 71'h200);
        check_eq("sw_stall_cycles", 71'(stall_n), 71'd2);

        // read and write both set behaves as a read
        drive(2'b11, 3'b011, 32'h0000_0088, 32'hCAFE_0000, 5'd12);
        exp_q.push_back({2'b11, 32'h0000_0055, 32'h0000_0088, 5'd12});
        mem_op(2, 32'h0000_0055);
        drive(2'b00, 3'b000, 32'h0, 32'h0, 5'd0);
        check_eq("rw_wb", mem_wb_out, exp_q.pop_front());
        check_eq("rw_we", 71'(we_s), 71'd0);

        // lw with no ack: timeout abort after 15 request cycles
        drive(2'b11, 3'b010, 32'h0000_0304, 32'h0, 5'd9);
        exp_q.push_back({2'b11, 32'h0, 32'h0000_0304, 5'd9});
        mem_op(0, 32'h0);
        drive(2'b00, 3'b000, 32'h0, 32'h0, 5'd0);
        check_eq("to_wb", mem_wb_out, exp_q.pop_front());
        check_eq("to_req_cycles", 71'(req_n), 71'd15);
        check_eq("to_err_pulses", 71'(err_n), 71'd1);
        check_eq("to_stall_cycles", 71'(stall_n), 71'd16);
        check_eq("to_err_after", 71'(mem_err), 71'd0);

        // reset on the 3rd request cycle, then a late ack
        drive(2'b11, 3'b010, 32'h0000_0400, 32'h0, 5'd4);
        tick(); tick(); tick();
        check_eq("rb_req3", 71'(dmem_req), 71'd1);
        rst_n = 1'b0;
        drive(2'b00, 3'b000, 32'h0, 32'h0, 5'd0);
        tick();
        check_eq("rb_req", 71'(dmem_req), 71'd0);
        check_eq("rb_stall", 71'(stall), 71'd0);
        check_eq("rb_wb", mem_wb_out, 71'h0);
        rst_n = 1'b1;
        dmem_ack = 1'b1; dmem_rdata = 32'hFFFF_FFFF;
        tick();
        dmem_ack = 1'b0;
        check_eq("late_ack_req", 71'(dmem_req), 71'd0);
        check_eq("late_ack_state", 71'(dbg_state), 71'd0);
        tick();
        check_eq("late_ack_wb", mem_wb_out, 71'h0);

        // beq resolution
        drive(2'b00, 3'b100, 32'h0, 32'h0, 5'd0);
        ex_mem_pc_4_off = 32'h0000_0040; ex_mem_zero = 1'b1;
        #1;
        check_eq("beq_taken", 71'(pc_src), 71'd1);
        check_eq("beq_target", 71'(branch_target), 71'h40);
        check_eq("beq_stall", 71'(stall), 71'd0);
        ex_mem_zero = 1'b0;
        #1;
        check_eq("beq_not_taken", 71'(pc_src), 71'd0);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
